sha2_msg_schedule: RTL and testbench

Message-schedule stage sitting directly upstream of the SHA-2 hash compute unit. It accepts padded message blocks as 16 words per block on an AXI4-Stream slave and emits the expanded schedule W_t on an AXI4-Stream master, one word per beat: 64 words per block for SHA-224/256, 80 for SHA-384/512. The hash compute unit consumes this stream directly as its per-round W_t input. TUSER is passed through per message and carries sha_type.

---
 rtl/sha2_msg_schedule.sv | 155 +++++++++++++++
 tb/tb_sha2_msg_schedule.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: takes 16 message words per block on an AXI4-Stream
// slave and streams W_0..W_L (L = 63 for SHA-224/256, 79 for SHA-384/512) on
// an AXI4-Stream master, one word per beat, feeding the hash round logic.
module sha2_msg_schedule #(
  parameter int S_AXIS_DATA_WIDTH  = 64,
  parameter int M_AXIS_DATA_WIDTH  = 64,
  parameter int S_AXIS_TUSER_WIDTH = 128,
  parameter int M_AXIS_TUSER_WIDTH = 128,
  parameter int SHA_TYPE_LSB       = 32
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  typedef enum logic {LOAD, EXPAND} state_t;

  state_t                        r_state;
  logic [6:0]                    r_t;
  logic                          r_msg_start;
  logic                          r_mode64;
  logic                          r_last_blk;
  logic [63:0]                   r_win [16];
  logic [M_AXIS_DATA_WIDTH-1:0]  r_m_tdata;
  logic [M_AXIS_TUSER_WIDTH-1:0] r_m_tuser;
  logic                          r_m_tvalid;
  logic                          r_m_tlast;

  logic        w_advance;
  logic        w_s_tready;
  logic        w_in_hs;
  logic        w_in_mode64;
  logic [63:0] w_in_word;
  logic [63:0] w_new;
  logic [63:0] w_shift_in;
  logic        w_shift_en;
  logic [6:0]  w_last_idx;

  // SHA-256 small sigma functions
  function automatic logic [31:0] sig0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // SHA-512 small sigma functions
  function automatic logic [63:0] sig0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // Handshake qualification, word-width selection and next schedule word
  always_comb begin
    w_advance   = !r_m_tvalid || m_axis_tready;
    w_s_tready  = (r_state == LOAD) && w_advance && axis_resetn;
    w_in_hs     = s_axis_tvalid && w_s_tready;
    // the first word of a message must already use the new message's width
    w_in_mode64 = r_msg_start ? s_axis_tuser[SHA_TYPE_LSB+1] : r_mode64;
    w_in_word   = w_in_mode64 ? s_axis_tdata : {32'd0, s_axis_tdata[31:0]};
    w_last_idx  = r_mode64 ? 7'd79 : 7'd63;
    if (r_mode64) begin
      w_new = sig1_64(r_win[14]) + r_win[9] + sig0_64(r_win[1]) + r_win[0];
    end else begin
      w_new = {32'd0, sig1_32(r_win[14][31:0]) + r_win[9][31:0]
                    + sig0_32(r_win[1][31:0]) + r_win[0][31:0]};
    end
    w_shift_in = (r_state == LOAD) ? w_in_word : w_new;
    w_shift_en = (r_state == LOAD) ? w_in_hs : w_advance;
  end

  // Sliding 16-word window; r_win[15] holds the newest word
  always_ff @(posedge axis_aclk) begin
    if (w_shift_en) begin
      for (int i = 0; i < 15; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[15] <= w_shift_in;
    end
  end

  // Block sequencing and the single output register
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state     <= LOAD;
      r_t         <= 7'd0;
      r_msg_start <= 1'b1;
      r_mode64    <= 1'b0;
      r_last_blk  <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tuser   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_advance) begin
            r_m_tvalid <= w_in_hs;
          end
          if (w_in_hs) begin
            r_m_tdata <= w_in_word;
            r_m_tlast <= 1'b0;
            r_t       <= r_t + 7'd1;
            if (r_msg_start) begin
              r_m_tuser   <= s_axis_tuser;
              r_mode64    <= s_axis_tuser[SHA_TYPE_LSB+1];
              r_msg_start <= 1'b0;
            end
            if (r_t == 7'd15) begin
              r_last_blk <= s_axis_tlast;
              r_state    <= EXPAND;
            end
          end
        end
        EXPAND: begin
          if (w_advance) begin
            r_m_tdata  <= w_new;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= (r_t == w_last_idx) && r_last_blk;
            if (r_t == w_last_idx) begin
              r_t     <= 7'd0;
              r_state <= LOAD;
              if (r_last_blk) begin
                r_msg_start <= 1'b1;
              end
            end else begin
              r_t <= r_t + 7'd1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign s_axis_tready = w_s_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Scoreboard bench for sha2_msg_schedule: a reference schedule model pushes
// expected beats when a block is driven; the output monitor pops and compares.
module tb_sha2_msg_schedule;

  typedef logic [63:0] blk_t [16];
  typedef struct {
    logic [63:0]  d;
    logic         l;
    logic [127:0] u;
  } exp_t;

  logic         axis_aclk;
  logic         axis_resetn;
  logic [63:0]  s_axis_tdata;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  int   n_chk;
  int   n_fail;
  exp_t exp_q[$];
  bit   rnd_ready;
  bit   mon_en;

  sha2_msg_schedule dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [63:0] rr32(input logic [63:0] x, input int n);
    logic [63:0] d;
    d = {x[31:0], x[31:0]} >> n;
    return {32'd0, d[31:0]};
  endfunction

  function automatic logic [63:0] bsig(input bit m64, input bit one, input logic [63:0] x);
    logic [63:0] x32;
    x32 = {32'd0, x[31:0]};
    if (m64) return one ? (rr64(x, 19) ^ rr64(x, 61) ^ (x >> 6))
                        : (rr64(x, 1) ^ rr64(x, 8) ^ (x >> 7));
    return one ? (rr32(x32, 17) ^ rr32(x32, 19) ^ (x32 >> 10))
               : (rr32(x32, 7) ^ rr32(x32, 18) ^ (x32 >> 3));
  endfunction

  // reference schedule for one block, appended to the scoreboard
  task automatic push_block(input blk_t wd, input bit m64, input bit blast, input logic [127:0] u);
    logic [63:0] w [80];
    logic [63:0] mask;
    int          lst;
    exp_t        e;
    mask = m64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    lst  = m64 ? 79 : 63;
    for (int i = 0; i < 16; i++) w[i] = wd[i] & mask;
    for (int i = 16; i <= lst; i++)
      w[i] = (bsig(m64, 1'b1, w[i-2]) + w[i-7] + bsig(m64, 1'b0, w[i-15]) + w[i-16]) & mask;
    for (int i = 0; i <= lst; i++) begin
      e.d = w[i];
      e.l = blast && (i == lst);
      e.u = u;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic [127:0] u, input bit l, output int cnt);
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    cnt = 0;
    while (1) begin
      @(negedge axis_aclk);
      if (s_axis_tready === 1'b1) break;
      cnt++;
      if (cnt > 5000) begin
        $display("FAIL send_timeout: s_axis_tready stuck at %0b for %0d cycles", s_axis_tready, cnt);
        n_fail++;
        $fatal(1, "input handshake never completed");
      end
    end
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_block(input blk_t wd, input logic [127:0] u, input bit blast,
                            input int nwords, output int stall0);
    int cnt;
    stall0 = 0;
    for (int i = 0; i < nwords; i++) begin
      send_word(wd[i], u, blast && (i == 15), cnt);
      if (i == 0) stall0 = cnt;
    end
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 3000) begin
      @(negedge axis_aclk);
      cnt++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(posedge axis_aclk);
    #1;
  endtask

  function automatic logic [127:0] mk_user(input logic [1:0] typ);
    logic [127:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[33:32] = typ;
    return u;
  endfunction

  // downstream ready: always high, or random when stalling is enabled
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge axis_aclk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // output monitor: hold-while-stalled checks and scoreboard compare
  logic         p_stall;
  logic [63:0]  p_data;
  logic [127:0] p_user;
  logic         p_last;
  exp_t         e_mon;
  initial p_stall = 1'b0;
  always @(negedge axis_aclk) begin
    if (!axis_resetn || !mon_en) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_vld", m_axis_tvalid, 1'b1);
        chk("hold_data", m_axis_tdata, p_data);
        chk("hold_last", m_axis_tlast, p_last);
        chk("hold_user", m_axis_tuser, p_user);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", m_axis_tdata, 0);
          chk("extra_beat_flag", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("wdata", m_axis_tdata, e_mon.d);
          chk("tlast", m_axis_tlast, e_mon.l);
          chk("tuser", m_axis_tuser, e_mon.u);
        end
      end
      p_stall = m_axis_tvalid && !m_axis_tready;
      p_data  = m_axis_tdata;
      p_last  = m_axis_tlast;
      p_user  = m_axis_tuser;
    end
  end

  blk_t         abc256, abc512, rb1, rb2, r32;
  logic [127:0] u1, u2;
  int           stall;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rnd_ready = 1'b0;
    mon_en = 1'b0;
    axis_resetn   = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      abc256[i] = 64'd0;
      abc512[i] = 64'd0;
      rb1[i] = {$urandom, $urandom};
      rb2[i] = {$urandom, $urandom};
      r32[i] = {32'hFFFF_FFFF, $urandom};
    end
    abc256[0]  = 64'h0000_0000_6162_6380;
    abc256[15] = 64'h18;
    abc512[0]  = 64'h6162_6380_0000_0000;
    abc512[15] = 64'h18;

    // reset state
    repeat (3) @(posedge axis_aclk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tuser", m_axis_tuser, 128'd0);
    chk("rst_tready", s_axis_tready, 1'b0);
    axis_resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge axis_aclk);
    #1;
    chk("idle_tready", s_axis_tready, 1'b1);

    // SHA-256 "abc"
    u1 = mk_user(2'd1);
    push_block(abc256, 1'b0, 1'b1, u1);
    send_block(abc256, u1, 1'b1, 16, stall);
    wait_drain();

    // SHA-512 "abc"
    u1 = mk_user(2'd2);
    push_block(abc512, 1'b1, 1'b1, u1);
    send_block(abc512, u1, 1'b1, 16, stall);
    wait_drain();

    // two-block SHA-256 message; sha_type change on block 2 must be ignored
    u1 = mk_user(2'd1);
    u2 = mk_user(2'd3);
    push_block(rb1, 1'b0, 1'b0, u1);
    push_block(rb2, 1'b0, 1'b1, u1);
    send_block(rb1, u1, 1'b0, 16, stall);
    send_block(rb2, u2, 1'b1, 16, stall);
    chk("inter_block_stall", stall, 48);
    wait_drain();

    // same vectors under random downstream backpressure
    rnd_ready = 1'b1;
    u1 = mk_user(2'd1);
    push_block(abc256, 1'b0, 1'b1, u1);
    send_block(abc256, u1, 1'b1, 16, stall);
    u2 = mk_user(2'd3);
    push_block(abc512, 1'b1, 1'b1, u2);
    send_block(abc512, u2, 1'b1, 16, stall);
    wait_drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge axis_aclk);
    #1;

    // asynchronous reset after 9 words of a block
    u1 = mk_user(2'd1);
    push_block(abc256, 1'b0, 1'b1, u1);
    send_block(abc256, u1, 1'b1, 9, stall);
    #2;
    axis_resetn = 1'b0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_tready", s_axis_tready, 1'b0);
    chk("midrst_tuser", m_axis_tuser, 128'd0);
    exp_q.delete();
    repeat (2) @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    u1 = mk_user(2'd1);
    push_block(abc256, 1'b0, 1'b1, u1);
    send_block(abc256, u1, 1'b1, 16, stall);
    wait_drain();

    // 32-bit mode (sha_type 0) with upper input lanes all ones
    rnd_ready = 1'b1;
    u1 = mk_user(2'd0);
    push_block(r32, 1'b0, 1'b1, u1);
    send_block(r32, u1, 1'b1, 16, stall);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
